// File: rtl/get_d_pipe_pkg.sv
// Shared definitions for the get_d digit-selection pipeline.
package get_d_pipe_pkg;
`include "bkm_defs.vh"

  typedef enum logic {
    MODE_EXP = MODE_E,
    MODE_LOG = MODE_L
  } mode_e;

  // neg and pos are mutually exclusive by construction of the thresholds.
  function automatic logic [1:0] digit_enc(input logic neg, input logic pos);
    if (neg) begin
      return DIG_NEG;
    end
    if (pos) begin
      return DIG_POS;
    end
    return DIG_ZERO;
  endfunction
endpackage

// File: rtl/get_d_pipe_if.sv
// Input/output handshake bundle of the get_d pipeline.
interface get_d_pipe_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic signed [W-1:0]     in_u;
  logic signed [W-1:0]     in_v;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_d_x;
  logic [1:0]              out_d_y;
  logic                    out_err;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, in_mode, in_u, in_v, in_tag, out_ready,
    input  in_ready, out_valid, out_d_x, out_d_y, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_u, in_v, in_tag, out_ready,
    output in_ready, out_valid, out_d_x, out_d_y, out_err, out_tag
  );
endinterface

// File: rtl/bkm_defs.vh
// Selection thresholds and range limit for the BKM digit selector, in units of 1/16,
// together with the mode and signed-digit encodings shared by the pipeline.
localparam int E_DX_NEG  = -6;
localparam int E_DX_POS  = 4;
localparam int E_DY_NEG  = -4;
localparam int E_DY_POS  = 4;
localparam int L_NEG     = -8;
localparam int L_POS     = 8;
localparam int RANGE_LIM = 48;

localparam logic       MODE_E   = 1'b0;
localparam logic       MODE_L   = 1'b1;
localparam logic [1:0] DIG_NEG  = 2'b11;
localparam logic [1:0] DIG_ZERO = 2'b00;
localparam logic [1:0] DIG_POS  = 2'b01;

// File: rtl/get_d_pipe_sel.sv
// Combinational digit selection from 1/16-resolution estimates; axis 0 is x (u), axis 1 is y (v).
module get_d_sel
  import get_d_pipe_pkg::*;
#(
  parameter int ET_W = 7
) (
  input  mode_e                  mode,
  input  logic signed [ET_W-1:0] u_t,
  input  logic signed [ET_W-1:0] v_t,
  output logic [1:0]             d_x,
  output logic [1:0]             d_y,
  output logic                   err
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam int E_NEG = (gi == 0) ? E_DX_NEG : E_DY_NEG;
    localparam int E_POS = (gi == 0) ? E_DX_POS : E_DY_POS;

    int         est;
    logic [1:0] dig;
    logic       oor;

    assign est = (gi == 0) ? int'(u_t) : int'(v_t);

    // L-mode selects the opposite sign to E-mode on a symmetric threshold.
    always_comb begin
      dig = DIG_ZERO;
      if (mode == MODE_EXP) begin
        dig = digit_enc(est <= E_NEG, est >= E_POS);
      end else begin
        dig = digit_enc(est >= L_POS, est <= L_NEG);
      end
      oor = (est >= RANGE_LIM) || (est < -RANGE_LIM);
    end
  end

  assign d_x = g_axis[0].dig;
  assign d_y = g_axis[1].dig;
  assign err = g_axis[0].oor | g_axis[1].oor;

endmodule

// File: rtl/get_d_pipe.sv
// Two-stage BKM digit-selection pipeline: S1 registers truncated estimates, S2 registers
// the selected digits; fully pipelined with valid/ready backpressure and an error counter.
module get_d_pipe
  import get_d_pipe_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = W - 3,
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clr_cnt,
  get_d_pipe_if.slave      bus,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SH   = FRAC - 4;
  localparam int ET_W = W - SH;

  logic                   s1_valid_reg;
  logic signed [ET_W-1:0] s1_u_reg;
  logic signed [ET_W-1:0] s1_v_reg;
  mode_e                  s1_mode_reg;
  logic [TAG_W-1:0]       s1_tag_reg;

  logic                   s2_valid_reg;
  logic [1:0]             s2_dx_reg;
  logic [1:0]             s2_dy_reg;
  logic                   s2_err_reg;
  logic [TAG_W-1:0]       s2_tag_reg;
  logic [CNT_W-1:0]       err_cnt_reg;

  logic [1:0]             sel_dx;
  logic [1:0]             sel_dy;
  logic                   sel_err;
  logic                   s2_adv;
  logic                   s1_adv;
  logic                   out_fire;

  assign s2_adv   = ~s2_valid_reg | bus.out_ready;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign out_fire = s2_valid_reg & bus.out_ready;

  assign bus.in_ready = ena & ~rst & s1_adv;

  get_d_sel #(.ET_W(ET_W)) u_sel (
    .mode (s1_mode_reg),
    .u_t  (s1_u_reg),
    .v_t  (s1_v_reg),
    .d_x  (sel_dx),
    .d_y  (sel_dy),
    .err  (sel_err)
  );

  // Arithmetic shift of the signed residual gives the two's-complement floor to 1/16.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_u_reg     <= '0;
      s1_v_reg     <= '0;
      s1_mode_reg  <= MODE_EXP;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_dx_reg    <= DIG_ZERO;
      s2_dy_reg    <= DIG_ZERO;
      s2_err_reg   <= 1'b0;
      s2_tag_reg   <= '0;
      err_cnt_reg  <= '0;
    end else if (ena) begin
      if (s1_adv) begin
        s1_valid_reg <= bus.in_valid;
        if (bus.in_valid) begin
          s1_u_reg    <= ET_W'(bus.in_u >>> SH);
          s1_v_reg    <= ET_W'(bus.in_v >>> SH);
          s1_mode_reg <= mode_e'(bus.in_mode);
          s1_tag_reg  <= bus.in_tag;
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_dx_reg  <= sel_dx;
          s2_dy_reg  <= sel_dy;
          s2_err_reg <= sel_err;
          s2_tag_reg <= s1_tag_reg;
        end
      end
      if (clr_cnt) begin
        err_cnt_reg <= '0;
      end else if (out_fire && s2_err_reg && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.out_d_x   = s2_dx_reg;
  assign bus.out_d_y   = s2_dy_reg;
  assign bus.out_err   = s2_err_reg;
  assign bus.out_tag   = s2_tag_reg;
  assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_get_d_pipe.sv
// Scoreboard bench for get_d_pipe: stimulus pushes reference results, a negedge monitor checks them.
module tb_get_d_pipe;
  localparam int W     = 16;
  localparam int FRAC  = 13;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;
  localparam int STEP  = 1 << (FRAC - 4);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt;

  get_d_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

  get_d_pipe #(.W(W), .FRAC(FRAC), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .clr_cnt (clr_cnt),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dx;
    int dy;
    int err;
    int tag;
    int acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int floor16(input int x);
    int q;
    q = x / STEP;
    if ((x % STEP) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  // Reference rules written directly as sixteenths: thresholds and the +-3.0 range.
  function automatic exp_t model(input bit m, input int u, input int v, input int tag, input int cyc);
    exp_t e;
    int ut, vt;
    ut = floor16(u);
    vt = floor16(v);
    if (!m) begin
      e.dx = (ut <= -6) ? -1 : (ut >= 4) ? 1 : 0;
      e.dy = (vt <= -4) ? -1 : (vt >= 4) ? 1 : 0;
    end else begin
      e.dx = (ut <= -8) ? 1 : (ut >= 8) ? -1 : 0;
      e.dy = (vt <= -8) ? 1 : (vt >= 8) ? -1 : 0;
    end
    e.err = (ut >= 48 || ut < -48 || vt >= 48 || vt < -48) ? 1 : 0;
    e.tag = tag;
    e.acc_cyc = cyc;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int         cyc = 0;
  bit         live = 0;
  int         exp_cnt = 0;
  bit         prev_hold = 0;
  logic [9:0] prev_out;
  logic [9:0] cur_out;
  bit         exp_rdy;
  bit         xfer;
  exp_t       h;

  always @(negedge clk) begin
    cyc++;
    xfer    = 0;
    cur_out = {bus.out_valid, bus.out_d_x, bus.out_d_y, bus.out_err, bus.out_tag};
    exp_rdy = ena && !rst && (sb_q.size() < 2 || bus.out_ready);
    if (live) begin
      chk("err_cnt", int'(err_cnt), exp_cnt);
      chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
      if (prev_hold) chk("hold_stable", int'(cur_out), int'(prev_out));
      if (sb_q.size() == 0) begin
        chk("out_valid_empty_pipe", int'(bus.out_valid), 0);
      end else if (bus.out_valid) begin
        chk("latency_ge2", int'((cyc - sb_q[0].acc_cyc) >= 2), 1);
        if (!rst && ena && bus.out_ready) begin
          xfer = 1;
          h = sb_q.pop_front();
          chk("d_x", int'($signed(bus.out_d_x)), h.dx);
          chk("d_y", int'($signed(bus.out_d_y)), h.dy);
          chk("err", int'(bus.out_err), h.err);
          chk("tag", int'(bus.out_tag), h.tag);
        end
      end
    end
    if (rst) begin
      sb_q.delete();
      exp_cnt   = 0;
      live      = 1;
      prev_hold = 0;
    end else begin
      if (live && ena) begin
        if (clr_cnt) exp_cnt = 0;
        else if (xfer && h.err != 0 && exp_cnt < CMAX) exp_cnt++;
        if (bus.in_valid && exp_rdy)
          sb_q.push_back(model(bus.in_mode, int'(bus.in_u), int'(bus.in_v), int'(bus.in_tag), cyc));
      end
      prev_hold = live && (!ena || (bus.out_valid && !bus.out_ready));
    end
    prev_out = cur_out;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit m, input int u, input int v, input int tag);
    int waits;
    bit acc;
    waits = 0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_u     = W'(u);
    bus.in_v     = W'(v);
    bus.in_tag   = TAG_W'(tag);
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waits++;
      if (!acc && waits > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (sb_q.size() > 0 && n < 100) begin
      tick(1);
      n++;
    end
    tick(1);
    chk("drain_empty", sb_q.size(), 0);
  endtask

  function automatic int rand_res();
    int k;
    case ($urandom_range(0, 3))
      0: return int'($signed(16'($urandom)));
      1: begin
        k = int'($urandom_range(0, 18));
        return (k - 9) * STEP + int'($urandom_range(0, 2)) - 1;
      end
      2: return ($urandom_range(0, 1) != 0 ? 24576 : -24576) + int'($urandom_range(0, 2)) - 1;
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  int  tbl_m[6] = '{0, 0, 0, 1, 1, 0};
  int  tbl_u[6] = '{2048, -2560, -2561, -4096, 4095, -3072};
  int  tbl_v[6] = '{0, -2048, 2047, 4096, -4097, 2048};
  int  idx;
  bit  saw_drop;
  logic [9:0] snap;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; clr_cnt = 1'b0;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_u = '0; bus.in_v = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_d_x", int'(bus.out_d_x), 0);
    chk("rst_d_y", int'(bus.out_d_y), 0);
    chk("rst_err", int'(bus.out_err), 0);
    chk("rst_tag", int'(bus.out_tag), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", int'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Latency into an empty pipe: not valid one cycle after accept, valid the next.
    send(0, 2048, 0, 1);
    @(negedge clk);
    chk("latency_c1_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("latency_c2_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    drain();

    for (int i = 0; i < 6; i++) send(tbl_m[i][0], tbl_u[i], tbl_v[i], i + 2);
    drain();

    // Error counting, saturation and clear priority.
    send(0, 1536 * 16, 0, 9);
    drain();
    chk("err_cnt_one", int'(err_cnt), 1);
    for (int i = 0; i < 300; i++) send(i[0], -1536 * 16 - 1, 1536 * 16, i);
    drain();
    chk("err_cnt_sat", int'(err_cnt), CMAX);
    bus.out_ready = 1'b0;
    send(1, 1536 * 16, 0, 5);
    tick(2);
    clr_cnt = 1'b1;
    bus.out_ready = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_wins", int'(err_cnt), 0);
    @(posedge clk); #1;
    drain();

    // Back-to-back tagged stream with a 3-cycle output stall.
    idx = 0;
    saw_drop = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      bus.out_ready = !(c >= 3 && c < 6);
      bus.in_valid  = 1'b1;
      bus.in_mode   = c[0];
      bus.in_u      = W'(int'($urandom_range(0, 8191)) - 4096);
      bus.in_v      = W'(int'($urandom_range(0, 8191)) - 4096);
      bus.in_tag    = TAG_W'(idx);
      @(negedge clk);
      if (bus.in_ready) idx++;
      else saw_drop = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("stream_sent", idx, 8);
    chk("in_ready_dropped", int'(saw_drop), 1);
    drain();

    // Reset with two transactions in flight.
    bus.out_ready = 1'b0;
    send(0, 2048, 2048, 3);
    send(1, -4096, 4096, 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_flush_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    tick(6);

    // ena low for 4 cycles with a result pending.
    bus.out_ready = 1'b0;
    send(0, -2561, -2048, 6);
    tick(2);
    @(negedge clk);
    snap = {bus.out_valid, bus.out_d_x, bus.out_d_y, bus.out_err, bus.out_tag};
    @(posedge clk); #1;
    ena = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    tick(4);
    @(negedge clk);
    chk("ena_freeze", int'({bus.out_valid, bus.out_d_x, bus.out_d_y, bus.out_err, bus.out_tag}), int'(snap));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ena = 1'b1;
    drain();

    // Randomised traffic with random backpressure and enable gaps.
    for (int i = 0; i < 800; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      ena           = ($urandom_range(0, 15) != 0);
      clr_cnt       = ($urandom_range(0, 63) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_mode   = $urandom_range(0, 1) != 0;
      bus.in_u      = W'(rand_res());
      bus.in_v      = W'(rand_res());
      bus.in_tag    = TAG_W'(i);
      tick(1);
    end
    bus.in_valid = 1'b0;
    ena = 1'b1;
    clr_cnt = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
